instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
- Bus initiator that drives the program counter's read/write strobes and fetches one instruction per cycle of operation.
- Each fetch reads the PC over the PC bus, then pulls 4 bytes from byte-wide instruction memory with a req/ack handshake.
- Assembles the bytes little-endian into a 32-bit instruction, writes PC+4 back to the PC, and presents the instruction to decode with a valid/ready handshake.
- Sits between the PC register, instruction memory and the decode stage.

Parameters:
- N, 32, address and instruction width in bits
- BYTES, 4, bytes per instruction (N/8); also the PC increment

Ports:
- i_clk  input  1  clock; all state changes on the rising edge
- i_rst  input  1  synchronous reset, active-high
- i_run  input  1  level; while 1 the unit fetches back-to-back
- o_pcReadEn  output  1  drives the PC read-enable; the PC drives the shared bus only while this is 1
- i_pcData  input  N  PC bus (tri-stated by the PC when not read-enabled)
- o_pcData  output  N  next PC value to be written
- o_pcWriteEn  output  1  PC write strobe; PC latches o_pcData at the edge where this is 1
- o_memReq  output  1  byte read request
- o_memAddr  output  N  byte address; stable while o_memReq=1
- i_memAck  input  1  memory has the byte on i_memByte this cycle
- i_memByte  input  8  read byte
- o_instr  output  N  assembled instruction
- o_instrValid  output  1  o_instr is valid
- i_instrReady  input  1  decode accepts o_instr
- o_busy  output  1  1 in every state except IDLE

Behaviour:
- Reset (i_rst=1 at an edge, from any state, including mid-handshake): state=IDLE; o_pcReadEn, o_pcWriteEn, o_memReq, o_instrValid, o_busy = 0; o_pcData, o_memAddr, o_instr, addrReg = 0; byteCnt = 0. Reset has priority over every other input.
- All outputs are registered or decoded from state only; none is combinational on any input.
- States and transitions:
  - IDLE: if i_run=1, go to RDPC.
  - RDPC: o_pcReadEn=1 for exactly 1 cycle. At that edge, addrReg <= i_pcData and byteCnt <= 0. Next state is REQ.
  - REQ: o_memReq=1 and o_memAddr = addrReg + byteCnt (mod 2^N). On the edge where i_memAck=1, o_instr[8*byteCnt +: 8] <= i_memByte.
    - If byteCnt = BYTES-1, go to UPD.
    - Otherwise byteCnt increments and the unit stays in REQ, keeping o_memReq high; the new address appears the next cycle.
    - With no ack, the unit waits indefinitely, holding address and request.
  - UPD: o_pcData = addrReg + BYTES (mod 2^N, wraps 0xFFFFFFFC -> 0x00000000); o_pcWriteEn=1 for exactly 1 cycle. Next state is VLD.
  - VLD: o_instrValid=1 and o_instr is held stable. On the edge with i_instrReady=1: go to RDPC if i_run=1, else IDLE. Without ready, the unit holds.
- o_pcReadEn and o_pcWriteEn are never 1 in the same cycle.
- o_pcData holds its last value outside UPD.
- i_memAck is ignored outside REQ.
- i_instrReady is ignored outside VLD.
- i_run is sampled only in IDLE and VLD. Dropping it mid-fetch completes the current instruction.
- Minimum latency with zero-wait memory: RDPC 1 + REQ 4 + UPD 1 = 6 cycles from leaving IDLE to o_instrValid=1.
- Back-to-back throughput with ready tied high: 7 cycles per instruction.
- byteCnt is 2 bits wide and saturates only by the state exit; it never wraps within a fetch.

Decomposition:
- Shared package `fetch_pkg`:
  - state encoding constants IDLE=3'd0, RDPC=3'd1, REQ=3'd2, UPD=3'd3, VLD=3'd4
  - BYTES_PER_INSTR=4
  - PC_INCR=4
- One natural sub-module, `fetch_byte_cnt`:
  - 2-bit counter with synchronous clear and increment-enable
  - provides byteCnt and a last-byte flag (cnt==3)
- Adders (addrReg+byteCnt, addrReg+4) stay inline.

Test Plan:
- Reset then i_run=1, PC bus=0x00000100, memory returns bytes 0x13,0x05,0x10,0x00 with zero-wait ack -> o_memAddr steps 0x100..0x103; o_pcWriteEn pulses with o_pcData=0x00000104; o_instrValid=1 with o_instr=0x00100513 exactly 6 cycles after leaving IDLE.
- Same as above but memory ack delayed 3 cycles per byte -> o_memReq held, o_memAddr stable during each wait; same o_instr; valid after 18 cycles.
- PC bus=0xFFFFFFFC -> o_memAddr 0xFFFFFFFC..0xFFFFFFFF; o_pcData=0x00000000 on write.
- Hold i_instrReady=0 for 5 cycles in VLD -> o_instr/o_instrValid stable, no new o_pcReadEn; ready=1 with i_run=1 -> o_pcReadEn next cycle.
- Assert i_rst during REQ after 2 bytes -> next cycle all outputs 0, state IDLE; re-run fetches from the PC again starting at byteCnt 0.
- Spurious i_memAck in IDLE/VLD and i_run toggled mid-fetch -> no byte capture, current fetch completes; IDLE entered after VLD when i_run=0.

Source files
------------

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared state encoding and constants for the instruction fetch unit
package fetch_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RDPC = 3'd1,
    REQ  = 3'd2,
    UPD  = 3'd3,
    VLD  = 3'd4
  } fetch_state_t;

  localparam int BYTES_PER_INSTR = 4;
  localparam int PC_INCR         = 4;

endpackage

// File: rtl/fetch_byte_cnt.sv
// rtl/fetch_byte_cnt.sv - 2-bit byte counter with synchronous clear and last-byte flag
import fetch_pkg::*;

module fetch_byte_cnt (
  input  logic       i_clk,
  input  logic       i_clr,
  input  logic       i_inc,
  output logic [1:0] o_cnt,
  output logic       o_last
);

  logic [1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      r_cnt <= 2'd0;
    end else if (i_inc) begin
      r_cnt <= r_cnt + 2'd1;
    end
  end

  assign o_cnt  = r_cnt;
  assign o_last = (r_cnt == 2'(BYTES_PER_INSTR - 1));

endmodule

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - reads PC, fetches 4 bytes little-endian, writes PC+4, hands instruction to decode
import fetch_pkg::*;

module instr_fetch_unit #(
  parameter int N     = 32,
  parameter int BYTES = 4
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_run,
  output logic         o_pcReadEn,
  input  logic [N-1:0] i_pcData,
  output logic [N-1:0] o_pcData,
  output logic         o_pcWriteEn,
  output logic         o_memReq,
  output logic [N-1:0] o_memAddr,
  input  logic         i_memAck,
  input  logic [7:0]   i_memByte,
  output logic [N-1:0] o_instr,
  output logic         o_instrValid,
  input  logic         i_instrReady,
  output logic         o_busy
);

  fetch_state_t r_state;
  fetch_state_t w_next;

  logic [N-1:0] r_addr;
  logic [N-1:0] r_instr;
  logic [N-1:0] r_pc_data;
  logic [1:0]   w_byte_cnt;
  logic         w_last;
  logic         w_clr;
  logic         w_inc;
  logic         w_ack_req;

  assign w_ack_req = (r_state == REQ) && i_memAck;
  assign w_clr     = i_rst || (r_state == RDPC);
  assign w_inc     = w_ack_req && !w_last;

  fetch_byte_cnt u_byte_cnt (
    .i_clk  (i_clk),
    .i_clr  (w_clr),
    .i_inc  (w_inc),
    .o_cnt  (w_byte_cnt),
    .o_last (w_last)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (i_run) w_next = RDPC;
      RDPC:    w_next = REQ;
      REQ:     if (w_ack_req && w_last) w_next = UPD;
      UPD:     w_next = VLD;
      VLD:     if (i_instrReady) w_next = i_run ? RDPC : IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Next PC is computed on the final byte so it is already stable for the whole UPD cycle.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_addr    <= '0;
      r_instr   <= '0;
      r_pc_data <= '0;
    end else begin
      if (r_state == RDPC) begin
        r_addr <= i_pcData;
      end
      if (w_ack_req) begin
        r_instr[8*w_byte_cnt +: 8] <= i_memByte;
        if (w_last) begin
          r_pc_data <= r_addr + N'(BYTES);
        end
      end
    end
  end

  assign o_pcReadEn   = (r_state == RDPC);
  assign o_pcWriteEn  = (r_state == UPD);
  assign o_memReq     = (r_state == REQ);
  assign o_instrValid = (r_state == VLD);
  assign o_busy       = (r_state != IDLE);
  assign o_memAddr    = r_addr + {{(N-2){1'b0}}, w_byte_cnt};
  assign o_pcData     = r_pc_data;
  assign o_instr      = r_instr;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - directed self-checking bench for instr_fetch_unit
module tb_instr_fetch_unit;

  logic        i_clk;
  logic        i_rst;
  logic        i_run;
  logic        o_pcReadEn;
  logic [31:0] i_pcData;
  logic [31:0] o_pcData;
  logic        o_pcWriteEn;
  logic        o_memReq;
  logic [31:0] o_memAddr;
  logic        i_memAck;
  logic [7:0]  i_memByte;
  logic [31:0] o_instr;
  logic        o_instrValid;
  logic        i_instrReady;
  logic        o_busy;

  logic [31:0] pc_val;
  logic [7:0]  mem_bytes [4];
  logic        ack_force;
  int          wait_cycles;
  int          wait_cnt;
  int          n_checks;
  int          n_pass;
  int          n_fail;

  instr_fetch_unit #(.N(32), .BYTES(4)) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_run        (i_run),
    .o_pcReadEn   (o_pcReadEn),
    .i_pcData     (i_pcData),
    .o_pcData     (o_pcData),
    .o_pcWriteEn  (o_pcWriteEn),
    .o_memReq     (o_memReq),
    .o_memAddr    (o_memAddr),
    .i_memAck     (i_memAck),
    .i_memByte    (i_memByte),
    .o_instr      (o_instr),
    .o_instrValid (o_instrValid),
    .i_instrReady (i_instrReady),
    .o_busy       (o_busy)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // PC bus carries junk when not read-enabled so a mistimed capture is visible.
  assign i_pcData  = o_pcReadEn ? pc_val : 32'hBAD0_BAD0;
  assign i_memByte = mem_bytes[o_memAddr[1:0]];
  assign i_memAck  = ack_force || (o_memReq && (wait_cnt == wait_cycles));

  always @(posedge i_clk) begin
    if (o_memReq && !i_memAck) wait_cnt <= wait_cnt + 1;
    else                       wait_cnt <= 0;
  end

  task automatic cyc();
    @(posedge i_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic load_mem(input logic [31:0] word);
    mem_bytes[0] = word[7:0];
    mem_bytes[1] = word[15:8];
    mem_bytes[2] = word[23:16];
    mem_bytes[3] = word[31:24];
  endtask

  int          n;
  int          bad;
  logic        prev_hold;
  logic [31:0] prev_addr;

  initial begin
    n_checks = 0; n_pass = 0; n_fail = 0;
    i_rst = 1'b1; i_run = 1'b0; i_instrReady = 1'b0;
    ack_force = 1'b0; wait_cycles = 0; pc_val = 32'h0;
    load_mem(32'h0);
    cyc(); cyc();
    check("rst_pcReadEn", {31'b0, o_pcReadEn}, 32'd0);
    check("rst_pcWriteEn", {31'b0, o_pcWriteEn}, 32'd0);
    check("rst_memReq", {31'b0, o_memReq}, 32'd0);
    check("rst_instrValid", {31'b0, o_instrValid}, 32'd0);
    check("rst_busy", {31'b0, o_busy}, 32'd0);
    check("rst_pcData", o_pcData, 32'd0);
    check("rst_memAddr", o_memAddr, 32'd0);
    check("rst_instr", o_instr, 32'd0);
    i_rst = 1'b0;

    // Zero-wait fetch from 0x100.
    pc_val = 32'h0000_0100;
    load_mem(32'h0010_0513);
    i_run = 1'b1;
    cyc();
    check("t1_rdpc_readEn", {31'b0, o_pcReadEn}, 32'd1);
    check("t1_rdpc_busy", {31'b0, o_busy}, 32'd1);
    for (int b = 0; b < 4; b++) begin
      cyc();
      check("t1_memReq", {31'b0, o_memReq}, 32'd1);
      check("t1_memAddr", o_memAddr, 32'h0000_0100 + b);
    end
    cyc();
    check("t1_upd_writeEn", {31'b0, o_pcWriteEn}, 32'd1);
    check("t1_upd_readEn", {31'b0, o_pcReadEn}, 32'd0);
    check("t1_upd_pcData", o_pcData, 32'h0000_0104);
    cyc();
    check("t1_valid_at_6", {31'b0, o_instrValid}, 32'd1);
    check("t1_instr", o_instr, 32'h0010_0513);
    check("t1_pcData_held", o_pcData, 32'h0000_0104);

    // Decode stalls for 5 cycles.
    for (int k = 0; k < 5; k++) begin
      cyc();
      check("t4_hold_valid", {31'b0, o_instrValid}, 32'd1);
      check("t4_hold_instr", o_instr, 32'h0010_0513);
      check("t4_hold_noRead", {31'b0, o_pcReadEn}, 32'd0);
    end
    i_instrReady = 1'b1;
    wait_cycles = 3;
    cyc();
    check("t4_restart_readEn", {31'b0, o_pcReadEn}, 32'd1);
    i_instrReady = 1'b0;

    // Same fetch with 3 wait cycles per byte; RDPC already entered, count is 0 here.
    n = 0; bad = 0; prev_hold = 1'b0; prev_addr = 32'h0;
    while (!o_instrValid && n < 60) begin
      cyc();
      n++;
      if (prev_hold && (!o_memReq || o_memAddr != prev_addr)) bad++;
      prev_hold = o_memReq && !i_memAck;
      prev_addr = o_memAddr;
    end
    check("t2_latency", n, 32'd18);
    check("t2_wait_stable", bad, 32'd0);
    check("t2_instr", o_instr, 32'h0010_0513);
    i_instrReady = 1'b1;
    i_run = 1'b0;
    cyc();
    check("t2_idle_busy", {31'b0, o_busy}, 32'd0);
    i_instrReady = 1'b0;
    wait_cycles = 0;

    // Address wrap at top of memory, with i_run toggled mid-fetch.
    pc_val = 32'hFFFF_FFFC;
    load_mem(32'hDEAD_BEEF);
    i_run = 1'b1;
    cyc();
    i_run = 1'b0;
    cyc();
    check("t3_addr0", o_memAddr, 32'hFFFF_FFFC);
    i_run = 1'b1;
    cyc();
    i_run = 1'b0;
    cyc();
    cyc();
    check("t3_addr3", o_memAddr, 32'hFFFF_FFFF);
    cyc();
    check("t3_wrap_writeEn", {31'b0, o_pcWriteEn}, 32'd1);
    check("t3_wrap_pcData", o_pcData, 32'h0000_0000);
    cyc();
    check("t3_instr", o_instr, 32'hDEAD_BEEF);

    // Spurious ack in VLD and IDLE must not touch the instruction.
    load_mem(32'h5555_5555);
    ack_force = 1'b1;
    cyc(); cyc();
    check("t6_vld_spur_instr", o_instr, 32'hDEAD_BEEF);
    check("t6_vld_still", {31'b0, o_instrValid}, 32'd1);
    i_instrReady = 1'b1;
    cyc();
    check("t6_idle_after_vld", {31'b0, o_busy}, 32'd0);
    cyc(); cyc();
    check("t6_idle_spur_instr", o_instr, 32'hDEAD_BEEF);
    check("t6_idle_stays", {31'b0, o_busy}, 32'd0);
    ack_force = 1'b0;
    i_instrReady = 1'b0;

    // Reset after two bytes of a fetch, then refetch from a fresh PC.
    pc_val = 32'h0000_0200;
    load_mem(32'h4433_2211);
    i_run = 1'b1;
    cyc(); cyc(); cyc(); cyc();
    check("t5_pre_rst_addr", o_memAddr, 32'h0000_0202);
    i_rst = 1'b1;
    cyc();
    check("t5_rst_memReq", {31'b0, o_memReq}, 32'd0);
    check("t5_rst_busy", {31'b0, o_busy}, 32'd0);
    check("t5_rst_memAddr", o_memAddr, 32'd0);
    check("t5_rst_instr", o_instr, 32'd0);
    check("t5_rst_pcData", o_pcData, 32'd0);
    check("t5_rst_readEn", {31'b0, o_pcReadEn}, 32'd0);
    i_rst = 1'b0;
    pc_val = 32'h0000_0300;
    load_mem(32'h1234_5678);
    cyc();
    check("t5_rerun_readEn", {31'b0, o_pcReadEn}, 32'd1);
    cyc();
    check("t5_rerun_addr0", o_memAddr, 32'h0000_0300);
    n = 0;
    while (!o_instrValid && n < 30) begin
      cyc();
      n++;
    end
    check("t5_rerun_latency", n, 32'd5);
    check("t5_rerun_instr", o_instr, 32'h1234_5678);
    check("t5_rerun_pcData", o_pcData, 32'h0000_0304);
    i_run = 1'b0;
    i_instrReady = 1'b1;
    cyc();
    check("t5_final_idle", {31'b0, o_busy}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
